// File: rtl/sdram_port_arbiter_if.sv
// Bundles the CPU, video and SDRAM-controller sides of the port arbiter into one interface.
// Latency: none; this is wiring only.
// Backpressure: level requests are held until the matching 1-cycle ack; the controller side holds mem_req until mem_ack.
// Ports: cpu_* (68000 bus side), vid_* (framebuffer prefetch side), mem_* (SDRAM controller side), timeout_err.
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 23
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [15:0]       cpu_wdata;
  logic [1:0]        cpu_be;
  logic              cpu_ack;
  logic [15:0]       cpu_rdata;

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_ack;
  logic [15:0]       vid_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [1:0]        mem_be;
  logic              mem_ack;
  logic [15:0]       mem_rdata;

  logic              timeout_err;

  // Arbiter side: consumes requests and controller responses, drives acks and the controller port.
  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    input  vid_req, vid_addr,
    input  mem_ack, mem_rdata,
    output cpu_ack, cpu_rdata, vid_ack, vid_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output timeout_err
  );

  // Environment side: requesters plus the SDRAM controller.
  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    output vid_req, vid_addr,
    output mem_ack, mem_rdata,
    input  cpu_ack, cpu_rdata, vid_ack, vid_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  timeout_err
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Shares one 16-bit SDRAM controller port between the CPU and the video prefetcher; video wins unless the CPU has aged out.
// Latency: request seen in IDLE at t, mem_req at t+1, requester ack one cycle after mem_ack (minimum t+2); grants 3 cycles apart.
// Backpressure: requests are level-held until ack; mem_req is held until mem_ack or until the watchdog aborts after TIMEOUT cycles.
// Ports: clk, reset_n (sync, active-low); bus = sdram_port_arbiter_if.master carrying cpu_*, vid_*, mem_* and timeout_err.
module sdram_port_arbiter #(
  parameter int ADDR_W       = 23,
  parameter int MAX_CPU_WAIT = 16,
  parameter int TIMEOUT      = 255
) (
  input  logic                         clk,
  input  logic                         reset_n,
  sdram_port_arbiter_if.master         bus
);

  localparam int WAIT_W = $clog2(MAX_CPU_WAIT + 1);
  localparam int WD_W   = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_CPU_WAIT);
  // Watchdog value during the last BUSY cycle before an abort.
  localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, CPU_BUSY, VID_BUSY, RELEASE} state_t;

  state_t              state_q, state_d;
  logic                own_cpu_q, own_cpu_d;
  logic [WAIT_W-1:0]   cpu_wait_q, cpu_wait_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [15:0]         mem_wdata_q, mem_wdata_d;
  logic [1:0]          mem_be_q, mem_be_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                vid_ack_q, vid_ack_d;
  logic [15:0]         cpu_rdata_q, cpu_rdata_d;
  logic [15:0]         vid_rdata_q, vid_rdata_d;
  logic                terr_q, terr_d;
  logic                grant_cpu;
  logic                finish;

  always_comb begin
    state_d     = state_q;
    own_cpu_d   = own_cpu_q;
    cpu_wait_d  = cpu_wait_q;
    wd_d        = wd_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    cpu_ack_d   = 1'b0;
    vid_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    vid_rdata_d = vid_rdata_q;
    terr_d      = terr_q;
    finish      = 1'b0;

    // Video has priority unless the CPU has been kept waiting long enough.
    grant_cpu = bus.cpu_req && (!bus.vid_req || (cpu_wait_q >= WAIT_MAX));

    case (state_q)
      IDLE: begin
        if (grant_cpu) begin
          state_d     = CPU_BUSY;
          own_cpu_d   = 1'b1;
          wd_d        = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.cpu_we;
          mem_addr_d  = bus.cpu_addr;
          mem_wdata_d = bus.cpu_wdata;
          mem_be_d    = bus.cpu_be;
        end else if (bus.vid_req) begin
          // Video has no write data; mem_wdata keeps its last value.
          state_d    = VID_BUSY;
          own_cpu_d  = 1'b0;
          wd_d       = '0;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = bus.vid_addr;
          mem_be_d   = 2'b11;
        end
      end
      CPU_BUSY, VID_BUSY: begin
        // A late mem_ack on the watchdog's final cycle still delivers its data.
        if (bus.mem_ack) begin
          finish = 1'b1;
          if (own_cpu_q) begin
            if (!mem_we_q) cpu_rdata_d = bus.mem_rdata;
          end else begin
            vid_rdata_d = bus.mem_rdata;
          end
        end else if (wd_q == WD_LAST) begin
          finish = 1'b1;
          terr_d = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
        if (finish) begin
          state_d   = RELEASE;
          mem_req_d = 1'b0;
          cpu_ack_d = own_cpu_q;
          vid_ack_d = !own_cpu_q;
        end
      end
      default: state_d = IDLE;  // RELEASE lasts exactly one cycle
    endcase

    // CPU ageing: counts cycles the CPU asks but does not own the port.
    if (!bus.cpu_req) begin
      cpu_wait_d = '0;
    end else if ((state_q == IDLE) && grant_cpu) begin
      cpu_wait_d = '0;
    end else if ((state_q == CPU_BUSY) || ((state_q == RELEASE) && own_cpu_q)) begin
      cpu_wait_d = cpu_wait_q;
    end else if (cpu_wait_q < WAIT_MAX) begin
      cpu_wait_d = cpu_wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      own_cpu_q   <= 1'b0;
      cpu_wait_q  <= '0;
      wd_q        <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      cpu_ack_q   <= 1'b0;
      vid_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      own_cpu_q   <= own_cpu_d;
      cpu_wait_q  <= cpu_wait_d;
      wd_q        <= wd_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      cpu_ack_q   <= cpu_ack_d;
      vid_ack_q   <= vid_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_rdata_q <= vid_rdata_d;
      terr_q      <= terr_d;
    end
  end

  assign bus.cpu_ack     = cpu_ack_q;
  assign bus.cpu_rdata   = cpu_rdata_q;
  assign bus.vid_ack     = vid_ack_q;
  assign bus.vid_rdata   = vid_rdata_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_be      = mem_be_q;
  assign bus.timeout_err = terr_q;

endmodule
